// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream (A5, N, 4*N
// little-endian data bytes, XOR checksum) and drives the BRAM write port.
module imem_loader #(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        word_count
);

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] MAX_N = 8'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state;
  logic [7:0]          r_n;
  logic [1:0]          r_byte_idx;
  logic [7:0]          r_csum;
  logic [23:0]         r_shift;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [7:0]          r_word_count;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_data;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                w_xfer;
  logic [31:0]         w_word;
  logic [7:0]          w_next_count;

  // Only the single write cycle stalls the stream.
  assign in_ready     = (r_state != S_WRITE);
  assign w_xfer       = in_valid && in_ready;
  assign w_word       = {in_data, r_shift};
  assign w_next_count = r_word_count + 8'd1;

  assign mem_write_enable = r_we;
  assign mem_addr         = r_addr;
  assign mem_data         = r_data;
  assign busy             = r_busy;
  assign done             = r_done;
  assign error            = r_error;
  assign word_count       = r_word_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_n          <= 8'd0;
      r_byte_idx   <= 2'd0;
      r_csum       <= 8'd0;
      r_shift      <= 24'd0;
      r_word_idx   <= ADDR_W'(0);
      r_word_count <= 8'd0;
      r_we         <= 1'b0;
      r_addr       <= ADDR_W'(0);
      r_data       <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_xfer && (in_data == SYNC)) begin
            r_state <= S_COUNT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            if ((in_data == 8'd0) || (in_data > MAX_N)) begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_n          <= in_data;
              r_word_idx   <= ADDR_W'(0);
              r_byte_idx   <= 2'd0;
              r_csum       <= 8'd0;
              r_word_count <= 8'd0;
              r_state      <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Bytes enter at the top so the first one ends up in [7:0].
          if (w_xfer) begin
            r_shift    <= {in_data, r_shift[23:8]};
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_addr  <= r_word_idx;
              r_data  <= w_word;
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          r_word_idx   <= r_word_idx + ADDR_W'(1);
          r_word_count <= w_next_count;
          r_state      <= (w_next_count == r_n) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (w_xfer) begin
            r_busy <= 1'b0;
            if (in_data == r_csum) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERROR;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction BRAM. Accepts a framed byte stream (from the UART receiver or a test harness) over a valid/ready handshake, assembles little-endian 32-bit words, and drives the `bram_sdp` write port (`clock_write` = `clock`) so the processor's read side fetches the loaded program. `busy` holds the processor in reset until the load completes.

## Interface
- `DEPTH`, default 128: number of words in the instruction memory; legal range 2..255.
- `ADDR_W`, default `$clog2(DEPTH)`: width of the BRAM address.
- `clock`  input  1  system clock, which also drives the BRAM write clock.
- `reset`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  `in_data` holds a byte.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  loader can accept a byte; a byte transfers on a posedge where `in_valid && in_ready`.
- `mem_write_enable`  output  1  BRAM write strobe.
- `mem_addr`  output  ADDR_W  BRAM write address.
- `mem_data`  output  32  BRAM write data.
- `busy`  output  1  load in progress; used to hold the processor in reset.
- `done`  output  1  last load completed with a good checksum; sticky.
- `error`  output  1  last load failed; sticky.
- `word_count`  output  8  number of words written in the current or last load.

## Operation
- Frame format: sync byte 0xA5, then count byte N, then 4·N data bytes, then checksum byte.
  - Data bytes are little-endian within each word: the first byte goes to [7:0].
  - The checksum is the XOR of all 4·N data bytes.
- States:
  - IDLE: accept and discard every byte except 0xA5. On 0xA5 go to COUNT, set `busy`, and clear `done` and `error`.
  - COUNT: accept N. If N == 0 or N > DEPTH, go to ERROR. Otherwise latch N, clear the word index, byte index, checksum and `word_count`, then go to DATA.
  - DATA: shift each byte into the assembly register, XOR it into the checksum, and increment the byte index (2 bits, wraps).
    - On the 4th byte, go to WRITE.
  - WRITE: lasts one cycle. Assert `mem_write_enable` with `mem_addr` = word index and `mem_data` = assembled word. Increment the word index and `word_count`.
    - If `word_count` now equals N, go to CHECK; otherwise go back to DATA.
  - CHECK: accept one byte. If it equals the checksum go to DONE, otherwise go to ERROR.
  - DONE: `done` = 1, `busy` = 0.
  - ERROR: `error` = 1, `busy` = 0.
  - In DONE and ERROR, 0xA5 starts a new load (same actions as in IDLE); all other bytes are discarded.
- `in_ready` = 1 in every state except WRITE.
- A failed load does not roll back BRAM contents: words already written stay in memory.
- Sync is detected only in IDLE, DONE and ERROR. A 0xA5 inside COUNT, DATA or CHECK is treated as data.
- Gaps in `in_valid` are allowed anywhere; state and partial words are held.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready` = 1; `mem_write_enable` = 0.
  - `mem_addr` = 0, `mem_data` = 0.
  - `busy` = 0, `done` = 0, `error` = 0, `word_count` = 0.
- All outputs are registered except `in_ready`, which is decoded from state.
- Write latency: the 4th byte of a word is accepted at edge k. `mem_write_enable` is high for exactly cycle k..k+1. `in_ready` is low in that same cycle, so the next byte is accepted at edge k+2 at the earliest.
- `busy` rises in the cycle after 0xA5 is accepted.
- `done` or `error` rises, and `busy` falls, in the cycle after the deciding byte (checksum byte, or bad count) is accepted.
- Reset asserted mid-load returns everything to reset values immediately. No further writes are issued, and a partial word is dropped.
- Throughput: one word per 5 cycles at full stream rate.

## Test plan
- Stream A5 01 13 00 00 00 13.
  - Exactly one write: addr 0, data 0x00000013.
  - Then `done` = 1, `error` = 0, `busy` = 0, `word_count` = 1.
- Stream A5 02 93 00 10 00 73 00 00 00 F0.
  - Writes 0x00100093 to addr 0, then 0x00000073 to addr 1.
  - `done` = 1.
  - `in_ready` is low exactly in each write cycle.
- Stream 55 FF A5 01 13 00 00 00 12 (garbage before sync, bad checksum).
  - The leading bytes are ignored.
  - One write of 0x00000013 to addr 0, then `error` = 1 and `done` = 0.
- Counts 00 and 0x81 (with DEPTH = 128).
  - `error` = 1 the cycle after the count byte; no writes.
  - A subsequent valid frame clears `error` and completes with `done`.
- Full load of N = 128 with `in_valid` toggling randomly.
  - 128 writes to addresses 0..127, each with the correct data.
  - `done` = 1, `word_count` = 128.
- Assert `reset` after the 2nd data byte of word 3.
  - All outputs return to reset values the same cycle; no write to addr 3.
  - A fresh frame then loads correctly.
